// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : debounce_pkg
//  Description : Shared definitions for the push-button debouncer: the
//                four-state qualification FSM encoding and its state type.
//                Kept in a package so other blocks that observe or reuse the
//                debouncer FSM agree on the encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    typedef logic [1:0] state_t;

    // Stable low level, waiting for the synchronized input to go high.
    localparam state_t IDLE_LOW   = 2'd0;
    // Input seen high; counting consecutive high samples.
    localparam state_t CHECK_HIGH = 2'd1;
    // Stable high level, waiting for the synchronized input to go low.
    localparam state_t IDLE_HIGH  = 2'd2;
    // Input seen low; counting consecutive low samples.
    localparam state_t CHECK_LOW  = 2'd3;

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer for a single asynchronous level.
//                Reusable by any block that needs to bring an external
//                level into the clk domain.
//  Ports       : clk  - sampling clock (rising edge)
//                RSTN - asynchronous active-low reset, clears both flops
//                d    - asynchronous input level
//                q    - synchronized level (second flop output)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic RSTN,
    input  logic d,
    output logic q
);

    // First stage may go metastable; only the second stage is consumed.
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : button_debouncer
//  Description : Debounces a raw push-button level. The input is brought
//                into the clk domain through sync_2ff, then a four-state
//                FSM accepts a new level only after it has been seen on
//                STABLE_CYCLES+1 consecutive synchronized samples (the
//                first disagreeing sample starts a check, STABLE_CYCLES
//                more confirm it). Any contrary sample aborts the check.
//  Parameters  : STABLE_CYCLES - samples required to accept a new level
//                                (1 .. 2**CNT_WIDTH-1)
//                CNT_WIDTH     - stability counter width
//  Ports       : clk       - clock, all state updates on rising edge
//                RSTN      - asynchronous active-low reset
//                btn_in    - raw, asynchronous, bouncing button level
//                btn_level - registered debounced level
//                btn_rise  - one-cycle pulse on accepted 0->1
//                btn_fall  - one-cycle pulse on accepted 1->0
//  Build macro : DEBOUNCE_PULSE_EN - when defined, btn_rise/btn_fall are
//                generated; when undefined, both are tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_WIDTH     = 20
) (
    input  logic clk,
    input  logic RSTN,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall
);

    localparam logic [CNT_WIDTH-1:0] C_STABLE = CNT_WIDTH'(STABLE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] C_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] C_ZERO   = '0;

    logic                 w_btn_sync;
    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 r_level;
    logic                 w_level_nxt;
    logic                 w_accept_high;
    logic                 w_accept_low;

    sync_2ff u_sync (
        .clk  (clk),
        .RSTN (RSTN),
        .d    (btn_in),
        .q    (w_btn_sync)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= IDLE_LOW;
            r_cnt   <= C_ZERO;
            r_level <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. The counter restarts from zero on every abort, so
    // a partial count can never carry over into a later check, and it
    // stops at C_STABLE because reaching it always leaves the CHECK state.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE_LOW: begin
                if (w_btn_sync) begin
                    w_state_nxt = CHECK_HIGH;
                    w_cnt_nxt   = C_ONE;
                end else begin
                    w_cnt_nxt   = C_ZERO;
                end
            end
            CHECK_HIGH: begin
                if (!w_btn_sync) begin
                    w_state_nxt = IDLE_LOW;
                    w_cnt_nxt   = C_ZERO;
                end else if (r_cnt == C_STABLE) begin
                    w_state_nxt = IDLE_HIGH;
                    w_cnt_nxt   = C_ZERO;
                end else begin
                    w_cnt_nxt   = r_cnt + C_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!w_btn_sync) begin
                    w_state_nxt = CHECK_LOW;
                    w_cnt_nxt   = C_ONE;
                end else begin
                    w_cnt_nxt   = C_ZERO;
                end
            end
            CHECK_LOW: begin
                if (w_btn_sync) begin
                    w_state_nxt = IDLE_HIGH;
                    w_cnt_nxt   = C_ZERO;
                end else if (r_cnt == C_STABLE) begin
                    w_state_nxt = IDLE_LOW;
                    w_cnt_nxt   = C_ZERO;
                end else begin
                    w_cnt_nxt   = r_cnt + C_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE_LOW;
                w_cnt_nxt   = C_ZERO;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: acceptance events drive the next debounced level.
    // ------------------------------------------------------------------
    always_comb begin
        w_accept_high = (r_state == CHECK_HIGH) &&  w_btn_sync && (r_cnt == C_STABLE);
        w_accept_low  = (r_state == CHECK_LOW)  && !w_btn_sync && (r_cnt == C_STABLE);
        w_level_nxt   = r_level;
        if (w_accept_high) begin
            w_level_nxt = 1'b1;
        end else if (w_accept_low) begin
            w_level_nxt = 1'b0;
        end
    end

    assign btn_level = r_level;

`ifdef DEBOUNCE_PULSE_EN
    // Pulses register on the same edge that updates the level, so each is
    // high exactly in the first cycle of the new level; the two acceptance
    // conditions are mutually exclusive by state.
    logic r_rise;
    logic r_fall;

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_accept_high;
            r_fall <= w_accept_low;
        end
    end

    assign btn_rise = r_rise;
    assign btn_fall = r_fall;
`else
    assign btn_rise = 1'b0;
    assign btn_fall = 1'b0;
`endif

endmodule : button_debouncer
`default_nettype wire
